// File: rtl/board_input_pkg.sv
// rtl/board_input_pkg.sv - shared types and constants for the board input debouncer
package board_input_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        RUN    = 2'd1,
        ASSERT = 2'd2
    } rst_state_t;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - synchronizer and counter debouncer for one pin
// BOARD_INPUT_EDGE_EN adds registered rise/fall pulses.
module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
`ifdef BOARD_INPUT_EDGE_EN
    output logic rise_pulse,
    output logic fall_pulse,
`endif
    output logic level
);
    import board_input_pkg::*;

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   stable_q;
    logic                   synced;
    logic                   accept;

    assign synced = sync_q[SYNC_STAGES-1];
    // The new level has persisted for DEBOUNCE_CYCLES consecutive cycles.
    assign accept = (synced != stable_q) && (cnt_q == CNT_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            if (synced == stable_q) begin
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q    <= '0;
                stable_q <= synced;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign level = stable_q;

`ifdef BOARD_INPUT_EDGE_EN
    logic rise_q;
    logic fall_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= accept & synced;
            fall_q <= accept & ~synced;
        end
    end

    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
`endif

endmodule

// File: rtl/board_input_debouncer.sv
// rtl/board_input_debouncer.sv - debounced board inputs plus stretched MCU reset
// BOARD_INPUT_EDGE_EN adds rise_pulse/fall_pulse ports.
module board_input_debouncer #(
    parameter int NUM_INPUTS        = 4,
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int RESET_CHANNEL     = 0,
    parameter int RESET_HOLD_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_INPUTS-1:0] raw_in,
    output logic [NUM_INPUTS-1:0] level_out,
`ifdef BOARD_INPUT_EDGE_EN
    output logic [NUM_INPUTS-1:0] rise_pulse,
    output logic [NUM_INPUTS-1:0] fall_pulse,
`endif
    output logic                  mcu_reset
);
    import board_input_pkg::*;

    localparam int HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clock      (clock),
            .reset      (reset),
            .raw        (raw_in[i]),
`ifdef BOARD_INPUT_EDGE_EN
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i]),
`endif
            .level      (level_out[i])
        );
    end

    rst_state_t        state_q;
    rst_state_t        state_d;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic              mcu_reset_q;
    logic              mcu_reset_d;
    logic              rst_level;

    assign rst_level = level_out[RESET_CHANNEL];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= HOLD;
            hold_q      <= '0;
            mcu_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            mcu_reset_q <= mcu_reset_d;
        end
    end

    // Reset is held for RESET_HOLD_CYCLES after power-up and after every release.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            HOLD: begin
                if (rst_level) begin
                    state_d = ASSERT;
                    hold_d  = '0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = RUN;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            RUN: begin
                if (rst_level) begin
                    state_d = ASSERT;
                end
            end
            ASSERT: begin
                if (!rst_level) begin
                    state_d = HOLD;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = HOLD;
                hold_d  = '0;
            end
        endcase
        mcu_reset_d = (state_d != RUN);
    end

    assign mcu_reset = mcu_reset_q;

endmodule

// File: doc/board_input_debouncer.md
# board_input_debouncer

Parametrised input-conditioning block for FPGA board tops. It brings NUM_INPUTS raw button/switch pins into the system clock domain and filters each one through a counter-based debouncer. It optionally emits one-cycle edge pulses per channel. It also derives a stretched, glitch-free active-high MCU reset from one designated channel. It sits between board pins and the rvsteel_mcu instance, replacing ad-hoc single-flop "debouncing" in board wrappers.

## Interface
- NUM_INPUTS, 4, number of conditioned input channels (≥1)
- DEBOUNCE_CYCLES, 500000, consecutive cycles a new level must persist before acceptance (≥1; 10 ms at 50 MHz)
- RESET_CHANNEL, 0, index of the channel that drives mcu_reset (< NUM_INPUTS)
- RESET_HOLD_CYCLES, 16, cycles mcu_reset stays asserted after release or power-up (≥1)

- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset (0 = reset); resets every register in the block
- raw_in  input  NUM_INPUTS  asynchronous board pins, active-high
- level_out  output  NUM_INPUTS  debounced levels
- rise_pulse  output  NUM_INPUTS  one-cycle pulse on accepted 0→1 (BOARD_INPUT_EDGE_EN only)
- fall_pulse  output  NUM_INPUTS  one-cycle pulse on accepted 1→0 (BOARD_INPUT_EDGE_EN only)
- mcu_reset  output  1  active-high reset for downstream logic

## Operation
- Per channel: 2-flop synchronizer (sync), debounced state (stable), counter of width $clog2(DEBOUNCE_CYCLES+1).
- Channel states:
  - STABLE: sync == stable, counter = 0.
  - PENDING: sync != stable. Counter increments each cycle.
    - Counter reaches DEBOUNCE_CYCLES-1 while sync still differs: stable <= sync, counter <= 0, edge pulse fires.
    - sync returns to stable before that point: counter <= 0, no output change.
- Glitches shorter than DEBOUNCE_CYCLES are fully rejected. Channels are independent; simultaneous changes on several channels are each handled in parallel.
- Counter never wraps: it is cleared on acceptance or abort.
- Reset FSM (driven by level_out[RESET_CHANNEL]):
  - HOLD: mcu_reset=1, hold counter counts 0..RESET_HOLD_CYCLES-1, then → RUN. Level high during HOLD → ASSERT; counter cleared.
  - RUN: mcu_reset=0. Level high → ASSERT.
  - ASSERT: mcu_reset=1 while level high. Level low → HOLD with counter 0.
- Reset values:
  - sync, stable, channel counters, rise_pulse, fall_pulse, level_out: 0.
  - FSM state: HOLD; hold counter: 0; mcu_reset: 1.
  - The block therefore always issues a power-on reset of RESET_HOLD_CYCLES cycles.
- reset asserted mid-debounce or mid-hold: everything returns to reset values immediately. Partial counts are discarded.

## Timing
- raw_in change sampled at edge k: sync valid at k+1, PENDING from k+2. level_out and the edge pulse update at edge k+1+DEBOUNCE_CYCLES (latency DEBOUNCE_CYCLES+1 cycles after the sampling edge).
- rise_pulse/fall_pulse: high exactly one cycle, coincident with the first cycle of the new level_out.
- mcu_reset: registered output.
  - Asserts one cycle after level_out[RESET_CHANNEL] rises.
  - Deasserts RESET_HOLD_CYCLES+1 cycles after level_out[RESET_CHANNEL] falls.
  - After reset deassertion, the first mcu_reset=0 occurs after RESET_HOLD_CYCLES cycles.
- All outputs are registered; there are no combinational paths from raw_in.

## Configuration
- BOARD_INPUT_EDGE_EN defined: rise_pulse/fall_pulse ports and their registers exist, with behaviour as above.
- Not defined: both ports and their registers are removed. level_out and mcu_reset behaviour is unchanged.

## Structure
- Package board_input_pkg:
  - reset FSM state typedef (HOLD, RUN, ASSERT)
  - localparam SYNC_STAGES = 2
- Sub-module debounce_channel: synchronizer, counter, stable register and optional edge pulses for one input. It is instantiated NUM_INPUTS times in a generate loop. The reset FSM lives in the top.

## Test plan
Bench: NUM_INPUTS=4, DEBOUNCE_CYCLES=8, RESET_CHANNEL=0, RESET_HOLD_CYCLES=4.
- Release reset with raw_in=0 → mcu_reset=1 for 4 cycles then 0; level_out=0; no pulses.
- raw_in[1] 0→1 held 20 cycles → level_out[1]=1 exactly 9 cycles after the sampling edge; rise_pulse[1] high 1 cycle; other channels unchanged.
- raw_in[2] high for 7 cycles then low (glitch) → level_out[2] stays 0, no pulse. Repeat with 8-cycle hold → accepted.
- raw_in[0] pressed 30 cycles then released → mcu_reset rises 1 cycle after level_out[0]=1. It falls 5 cycles after level_out[0]=0. Re-press during HOLD → mcu_reset stays 1 and the hold count restarts.
- raw_in[3:1] toggled on the same cycle → all three accepted on the same cycle with independent pulses.
- Assert reset while channel 1 is mid-count (counter=5) → all outputs return to reset values immediately. After release, a full 8-cycle debounce is required again.
